branch_resolver: RTL

Parametrised, registered branch/jump resolution stage for the CPU pipeline. It computes jump and branch targets, evaluates the branch condition, and checks the result against the prediction carried down from fetch. On a mispredict it issues a redirect with the correct PC. It also contains an optional branch history table (BHT) of 2-bit saturating counters, which fetch queries combinationally and which is trained at resolve.

---
 rtl/br_pkg.sv | 32 +++
 rtl/br_bht.sv | 31 +++
 rtl/branch_resolver.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/br_pkg.sv
// Shared constants, counter type and saturating update for branch resolution.
package br_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  function automatic ctr_t sat_update(
    input ctr_t c,
    input logic t
  );
    ctr_t r;
    r = c;
    if (t) begin
      if (c != ST) r = c + 2'd1;
    end else begin
      if (c != SNT) r = c - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/br_bht.sv
// Branch history table: 2-bit counters, async init to WNT,
// combinational read for fetch, synchronous training at resolve.
module br_bht
  import br_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic                     rd_taken,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic                     wr_taken
);

  ctr_t tbl [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= WNT;
      end
    end else if (wr_en) begin
      tbl[wr_idx] <= sat_update(tbl[wr_idx], wr_taken);
    end
  end

  assign rd_taken = tbl[rd_idx][1];

endmodule

// File: rtl/branch_resolver.sv
// Registered branch/jump resolve stage with redirect on mispredict.
// BHT storage is built only when BRANCH_RESOLVER_BHT_EN is defined.
module branch_resolver
  import br_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            en,
  input  logic            flush,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic            is_branch,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] r1,
  input  logic [XLEN-1:0] r2,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            fetch_pred_taken,
  output logic            out_valid,
  output logic            redirect,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] link,
  output logic            taken,
  output logic            EQ,
  output logic            NE,
  output logic            LT,
  output logic            GE,
  output logic            misalign,
  output logic            illegal
);

  localparam int IW = $clog2(BHT_DEPTH);

  logic            accept;
  logic            pred;
  logic            legal;
  logic            eq;
  logic            lt;
  logic            cond;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] n_target;
  logic [XLEN-1:0] n_pc;
  logic            n_taken;
  logic            n_redirect;
  logic [3:0]      n_flags;
  logic            n_mis;
  logic            n_ill;
  logic            unused_fetch;

  assign accept       = in_valid && en && !flush;
  assign unused_fetch = ^fetch_pc;

`ifdef BRANCH_RESOLVER_BHT_EN
  br_bht #(
    .DEPTH(BHT_DEPTH)
  ) u_bht (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (fetch_pc[IW+1:2]),
    .rd_taken(fetch_pred_taken),
    .wr_en   (accept && is_branch && legal),
    .wr_idx  (pc[IW+1:2]),
    .wr_taken(n_taken)
  );
  assign pred = pred_taken;
`else
  logic unused_pred;
  assign fetch_pred_taken = 1'b0;
  assign pred             = 1'b0;
  assign unused_pred      = pred_taken;
`endif

  always_comb begin
    legal = (func3 != 3'b010) && (func3 != 3'b011);
    eq    = (r1 == r2);
    lt    = func3[1] ? (r1 < r2) : ($signed(r1) < $signed(r2));
    cond  = 1'b0;
    unique case (func3)
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = !eq;
      F3_BLT:  cond = lt;
      F3_BGE:  cond = !lt;
      F3_BLTU: cond = lt;
      F3_BGEU: cond = !lt;
      default: cond = 1'b0;
    endcase

    pc4        = pc + XLEN'(4);
    n_target   = pc + imm;
    n_taken    = 1'b0;
    n_redirect = 1'b0;
    n_flags    = 4'b0000;
    n_ill      = 1'b0;
    unique case (1'b1)
      is_jal: begin
        n_taken    = 1'b1;
        n_redirect = 1'b1;
      end
      is_jalr: begin
        n_target   = (r1 + imm) & ~XLEN'(1);
        n_taken    = 1'b1;
        n_redirect = 1'b1;
      end
      is_branch: begin
        if (legal) begin
          n_taken    = cond;
          n_redirect = (cond != pred);
          n_flags    = {eq, !eq, lt, !lt};
        end else begin
          n_ill = 1'b1;
        end
      end
      default: ;
    endcase

    n_pc  = n_taken ? n_target : pc4;
    n_mis = n_taken && n_target[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      redirect  <= 1'b0;
      pc_out    <= '0;
      link      <= '0;
      taken     <= 1'b0;
      EQ        <= 1'b0;
      NE        <= 1'b0;
      LT        <= 1'b0;
      GE        <= 1'b0;
      misalign  <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      redirect  <= 1'b0;
      taken     <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
      if (in_valid) begin
        redirect         <= n_redirect;
        pc_out           <= n_pc;
        link             <= pc4;
        taken            <= n_taken;
        {EQ, NE, LT, GE} <= n_flags;
        misalign         <= n_mis;
        illegal          <= n_ill;
      end
    end
  end

endmodule
